edge_event_scheduler: RTL and testbench
=======================================

Name: edge_event_scheduler

Overview:
Tick-paced scheduler that turns rising edges on N slow level inputs (switches) into a serialized stream of visible events on one shared indicator path. Per-channel edge detection is sampled only on the slow tick from the clockTick divider. Pending edges are granted round-robin, and each grant is held for HOLD_TICKS ticks, so every event stays visible on an LED. Sits between the clockTick pulse and the board LEDs/7-seg in visual-test tops.

Parameters:
N, 4, number of level input channels (2..16)
HOLD_TICKS, 2, ticks evt_valid stays high per grant (>=1)
IDXW, 2, channel index width, must equal clog2(N)
CNTW, 4, hold counter width, must hold HOLD_TICKS-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  one-clk-wide enable pulse from clockTick; all state advances only when tick=1 (except clr_overflow)
level  input  N  slow level inputs (pre-synchronized)
clr_overflow  input  1  synchronous clear of all overflow bits
evt_valid  output  1  event currently being presented
evt_ch  output  IDXW  channel of the presented event; 0 when evt_valid=0
evt_start  output  1  one-clk pulse on the tick cycle a grant is made
pending  output  N  registered per-channel pending flags
overflow  output  N  sticky: an edge was lost on that channel

Behaviour:
- Reset (reset=0, async): level_q=0, pending=0, overflow=0, state=IDLE, last_ch=N-1, hold_cnt=0; all outputs 0.
- Edge: rise[i] = tick & level[i] & ~level_q[i]. level_q<=level on tick only. A channel already high at the first tick after reset counts as an edge.
- Arbitration uses the registered pending at the start of the cycle. An edge detected on the same tick is not eligible until the next tick.
- Round-robin winner: first set pending bit searching last_ch+1, last_ch+2, ... modulo N. After reset, channel 0 has top priority.
- States (2-bit): IDLE=00, HOLD=01, GAP=10. Unused encoding 11 -> IDLE on the next clk.
  - IDLE: on tick with pending!=0: grant winner w. Then state=HOLD, evt_valid=1, evt_ch=w, last_ch=w, pending[w] cleared, hold_cnt=HOLD_TICKS-1, evt_start=1 for that clk only.
  - HOLD: on tick: if hold_cnt==0 -> GAP with evt_valid=0 and evt_ch=0; else hold_cnt-1.
  - GAP: evt_valid=0 for exactly one tick period. On tick: if pending!=0, grant as in IDLE -> HOLD; else -> IDLE.
- Event timing: evt_valid high for exactly HOLD_TICKS tick periods. There is at least one tick period low between consecutive events.
- pending update on a tick cycle, per channel: next = (pending & ~grant_mask) | rise.
  - Rise and grant on the same channel in the same tick: pending stays 1 (new event), no overflow.
  - Rise while pending[i]=1 and channel i not granted this tick: pending stays 1, overflow[i]<=1.
- Overflow clear: clr_overflow=1 clears all overflow bits on any clk. If a set condition occurs in the same cycle, set wins for that bit.
- tick=0: no state, pending, level_q or hold_cnt change. Level changes that revert between ticks are invisible by design.
- Reset mid-event: evt_valid drops asynchronously and queued events are discarded.

Decomposition:
- Package edge_evt_pkg:
  - state encoding constants ST_IDLE, ST_HOLD, ST_GAP
  - default N and HOLD_TICKS
  - function clog2 for IDXW/CNTW checks
- One combinational sub-module, edge_evt_rr_pick:
  - inputs: req[N-1:0], last[IDXW-1:0]
  - outputs: any, idx[IDXW-1:0]
  - reusable, and unit-tested separately.

Test Plan:
All scenarios use N=4, HOLD_TICKS=2, tick every 4 clks.
1. Reset with level=4'b0000, then raise level[2] -> pending=4'b0100 after that tick. Next tick: evt_start pulse, evt_ch=2, evt_valid high for 8 clks, then low for 4 clks; pending=0.
2. Raise level=4'b1011 on one tick -> events in order ch0, ch1, ch3. Each has valid for 2 ticks with a 1-tick gap; no overflow.
3. Round-robin fairness: with last_ch=1, hold pending {0,1} continuously re-armed -> grants alternate 0,1,0,1 and never starve either channel.
4. Overflow: toggle level[3] 0->1->0->1 over 4 ticks while ch0 holds the indicator, with ch3 not granted -> overflow=4'b1000. clr_overflow pulse -> 0. Clear coincident with a new set -> remains 4'b1000.
5. Same-tick grant and rise on ch1 -> pending[1] stays 1 and overflow[1] stays 0. A second ch1 event follows after the gap.
6. Assert reset mid-HOLD (between ticks) -> evt_valid, pending, overflow and evt_ch are 0 immediately, without waiting for a clk edge. After release, level already high gives an edge on the first tick.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types and defaults for the tick-paced edge event scheduler.
// Revision: 1.0
`default_nettype none

package edge_evt_pkg;

  localparam int DEF_N          = 4;
  localparam int DEF_HOLD_TICKS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_evt_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping modulo N.
// Revision: 1.0
`default_nettype none

module edge_evt_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  int best;

  // Each requester's distance past 'last'; smallest distance wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i + N - int'(last) - 1) % N) < best)) begin
        best = (i + N - int'(last) - 1) % N;
        any  = 1'b1;
        idx  = IDXW'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_scheduler.sv
// Serializes tick-sampled rising edges on N level inputs into held, gapped indicator events.
// Revision: 1.0
`default_nettype none

module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int IDXW       = 2,
  parameter int CNTW       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N-1:0]    level,
  input  logic            clr_overflow,
  output logic            evt_valid,
  output logic [IDXW-1:0] evt_ch,
  output logic            evt_start,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overflow
);

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    level_q;
  logic [N-1:0]    rise;
  logic [N-1:0]    grant_mask;
  logic [N-1:0]    ovf_set;
  logic [IDXW-1:0] last_ch;
  logic [IDXW-1:0] cur_ch;
  logic [IDXW-1:0] win_idx;
  logic [CNTW-1:0] hold_cnt;
  logic            win_any;
  logic            grant;

  assign rise    = {N{tick}} & level & ~level_q;
  assign ovf_set = rise & pending & ~grant_mask;

  edge_evt_rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req  (pending),
    .last (last_ch),
    .any  (win_any),
    .idx  (win_idx)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && win_any) begin
          grant      = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick && (hold_cnt == '0)) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (tick) begin
          if (win_any) begin
            grant      = 1'b1;
            state_next = ST_HOLD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      level_q   <= '0;
      pending   <= '0;
      overflow  <= '0;
      last_ch   <= IDXW'(N - 1);
      cur_ch    <= '0;
      hold_cnt  <= '0;
      evt_start <= 1'b0;
    end else begin
      state     <= state_next;
      evt_start <= grant;
      // Set beats a coincident clear on the same bit.
      overflow  <= (overflow & ~{N{clr_overflow}}) | ovf_set;
      if (tick) begin
        level_q <= level;
        pending <= (pending & ~grant_mask) | rise;
      end
      if (grant) begin
        last_ch  <= win_idx;
        cur_ch   <= win_idx;
        hold_cnt <= CNTW'(HOLD_TICKS - 1);
      end else if (tick && (state == ST_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign evt_valid = (state == ST_HOLD);
  assign evt_ch    = evt_valid ? cur_ch : '0;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_scheduler.sv
// Directed self-checking bench for edge_event_scheduler (N=4, HOLD_TICKS=2, tick every 4 clks).
`default_nettype none

module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] level;
  logic       clr_overflow;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_start;
  logic [3:0] pending;
  logic [3:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt;
  int gcount;
  logic start_seen;
  logic start_extra;

  always #5 clk = ~clk;

  edge_event_scheduler #(
    .N          (4),
    .HOLD_TICKS (2),
    .IDXW       (2),
    .CNTW       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .level        (level),
    .clr_overflow (clr_overflow),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_start    (evt_start),
    .pending      (pending),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    tick         = 1'b0;
    clr_overflow = 1'b0;
    level        = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One tick period of 4 clks; tick (and optional clear) is high for the first clk only.
  task automatic step(input logic [3:0] lv, input logic clr_t);
    @(negedge clk);
    valid_cnt   += int'(evt_valid);
    level        = lv;
    tick         = 1'b1;
    clr_overflow = clr_t;
    @(negedge clk);
    valid_cnt   += int'(evt_valid);
    tick         = 1'b0;
    clr_overflow = 1'b0;
    start_seen   = evt_start;
    start_extra  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      valid_cnt  += int'(evt_valid);
      start_extra = start_extra | evt_start;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_ch2 [3];
    exp_ch2 = '{2'd0, 2'd1, 2'd3};
    reset = 1'b0; tick = 1'b0; clr_overflow = 1'b0; level = 4'b0000;
    valid_cnt = 0;

    // 1: reset state, single event on ch2
    repeat (2) @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_start", evt_start, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    step(4'b0000, 1'b0);
    check("s1_idle_pending", pending, 0);
    step(4'b0100, 1'b0);
    check("s1_pending", pending, 4'b0100);
    check("s1_not_yet_valid", evt_valid, 0);
    valid_cnt = 0;
    step(4'b0100, 1'b0);
    check("s1_start", start_seen, 1);
    check("s1_start_width", start_extra, 0);
    check("s1_ch", evt_ch, 2);
    check("s1_valid", evt_valid, 1);
    check("s1_pending_clr", pending, 0);
    step(4'b0100, 1'b0);
    check("s1_valid_hold", evt_valid, 1);
    step(4'b0100, 1'b0);
    check("s1_gap_valid", evt_valid, 0);
    check("s1_gap_ch", evt_ch, 0);
    step(4'b0100, 1'b0);
    check("s1_valid_clks", valid_cnt, 8);

    // 2: three simultaneous edges serialized 0,1,3
    do_reset();
    step(4'b0000, 1'b0);
    step(4'b1011, 1'b0);
    check("s2_pending", pending, 4'b1011);
    for (int i = 0; i < 9; i++) begin
      step(4'b1011, 1'b0);
      if (i % 3 == 0) begin
        check("s2_start", start_seen, 1);
        check("s2_ch", evt_ch, exp_ch2[i / 3]);
      end else if (i % 3 == 1) begin
        check("s2_hold_valid", evt_valid, 1);
      end else begin
        check("s2_gap_valid", evt_valid, 0);
      end
    end
    check("s2_pending_end", pending, 0);
    check("s2_overflow", overflow, 0);

    // 3: fairness with ch0/ch1 continuously re-armed
    do_reset();
    gcount = 0;
    for (int t = 1; t <= 14; t++) begin
      step((t % 2 == 1) ? 4'b0011 : 4'b0000, 1'b0);
      if (start_seen) begin
        check("s3_rr_ch", evt_ch, (gcount % 2 == 0) ? 0 : 1);
        gcount++;
      end
    end
    check("s3_grants", gcount, 5);

    // 4: overflow on ch3 while ch0/ch1 are served, clear, clear-vs-set
    do_reset();
    step(4'b1011, 1'b0);
    check("s4_pending", pending, 4'b1011);
    step(4'b0011, 1'b0);
    check("s4_ch0", evt_ch, 0);
    step(4'b1011, 1'b0);
    check("s4_overflow", overflow, 4'b1000);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    check("s4_cleared", overflow, 0);
    check("s4_pending_kept", pending, 4'b1010);
    step(4'b0011, 1'b0);
    step(4'b1011, 1'b1);
    check("s4_ch1", evt_ch, 1);
    check("s4_set_wins", overflow, 4'b1000);
    check("s4_pending2", pending, 4'b1000);

    // 5: same-tick grant and rise on ch1
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    check("s5_pending_wait", pending, 4'b0010);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    check("s5_start", start_seen, 1);
    check("s5_ch", evt_ch, 1);
    check("s5_pending_kept", pending, 4'b0010);
    check("s5_no_overflow", overflow, 0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    check("s5_gap", evt_valid, 0);
    step(4'b0011, 1'b0);
    check("s5_start2", start_seen, 1);
    check("s5_ch2", evt_ch, 1);
    check("s5_pending_end", pending, 0);

    // 6: asynchronous reset mid-hold
    step(4'b0111, 1'b0);
    check("s6_valid_before", evt_valid, 1);
    check("s6_pending_before", pending, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_valid", evt_valid, 0);
    check("s6_async_ch", evt_ch, 0);
    check("s6_async_pending", pending, 0);
    check("s6_async_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    step(4'b0111, 1'b0);
    check("s6_first_tick_edges", pending, 4'b0111);
    step(4'b0111, 1'b0);
    check("s6_regrant_ch", evt_ch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
